// File: rtl/alu_exec_ctrl_pkg.sv
// alu_exec_ctrl_pkg
// Shared definitions for the ALU execution sequencer.
// It holds:
//   - register-file geometry (count, index width, data width)
//   - opcode and flag widths
//   - PSR bit positions, in the same order as the ALU flag bus {Z,C,O,N,L}
//   - the sequencer state encoding
package alu_exec_ctrl_pkg;

  localparam int NUM_REGS = 16;
  localparam int REG_AW   = 4;
  localparam int DATA_W   = 16;
  localparam int OP_W     = 8;
  localparam int FLAG_W   = 5;

  localparam int PSR_Z = 4;
  localparam int PSR_C = 3;
  localparam int PSR_O = 2;
  localparam int PSR_N = 1;
  localparam int PSR_L = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// alu_exec_ctrl_if
// Bundles the decoder handshake, the external ALU connection, the status
// outputs and the debug read port of the sequencer.
//
// Signal groups:
//   decoder  : in_valid, in_ready, in_op, in_rdest, in_rsrc, in_wb, in_fwe
//   ALU      : alu_a, alu_b, alu_op, alu_cin (to the ALU)
//              alu_c, alu_flags (from the ALU)
//   status   : psr, done
//   debug    : dbg_addr, dbg_data
//
// Modports:
//   slave  : the sequencer's view of the bundle
//   master : the surrounding logic's view (decoder, ALU, debug host)
interface alu_exec_ctrl_if;
  import alu_exec_ctrl_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [REG_AW-1:0] in_rdest;
  logic [REG_AW-1:0] in_rsrc;
  logic              in_wb;
  logic              in_fwe;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic              alu_cin;
  logic [DATA_W-1:0] alu_c;
  logic [FLAG_W-1:0] alu_flags;

  logic [FLAG_W-1:0] psr;
  logic              done;

  logic [REG_AW-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport slave (
    input  in_valid, in_op, in_rdest, in_rsrc, in_wb, in_fwe,
    input  alu_c, alu_flags, dbg_addr,
    output in_ready, alu_a, alu_b, alu_op, alu_cin, psr, done, dbg_data
  );

  modport master (
    output in_valid, in_op, in_rdest, in_rsrc, in_wb, in_fwe,
    output alu_c, alu_flags, dbg_addr,
    input  in_ready, alu_a, alu_b, alu_op, alu_cin, psr, done, dbg_data
  );

endinterface

// File: rtl/alu_exec_ctrl_regfile.sv
// alu_exec_ctrl_regfile
// 16 x 16-bit register file for the ALU sequencer. There is no hard-wired
// zero register, so every entry can be written.
//
// Ports:
//   clk, reset             : clock, synchronous active-high reset (clears all)
//   i_rdEn                 : capture both read ports this cycle
//   i_raddrA / i_raddrB    : read indices
//   o_rdataA / o_rdataB    : captured operands, held until the next i_rdEn
//   i_we, i_waddr, i_wdata : single write port
//   i_dbgAddr / o_dbgData  : asynchronous debug read
module alu_exec_ctrl_regfile
  import alu_exec_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_rdEn,
  input  logic [REG_AW-1:0] i_raddrA,
  input  logic [REG_AW-1:0] i_raddrB,
  output logic [DATA_W-1:0] o_rdataA,
  output logic [DATA_W-1:0] o_rdataB,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_dbgAddr,
  output logic [DATA_W-1:0] o_dbgData
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_rdataA;
  logic [DATA_W-1:0] r_rdataB;

  // Storage array. Reset wins over a write in the same cycle, so an
  // instruction that is in write-back when reset arrives leaves no trace.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Operand capture registers. They change only when a new read is requested,
  // so the ALU inputs stay steady for the rest of the instruction and while
  // the block is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdataA <= '0;
      r_rdataB <= '0;
    end else if (i_rdEn) begin
      r_rdataA <= r_regs[i_raddrA];
      r_rdataB <= r_regs[i_raddrB];
    end
  end

  assign o_rdataA  = r_rdataA;
  assign o_rdataB  = r_rdataB;
  assign o_dbgData = r_regs[i_dbgAddr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl
// Sequencer that sits between instruction decode and an external
// combinational ALU. It owns the register file and the PSR. For each
// accepted instruction it steps through READ -> EXEC -> WB. It then writes
// back the result and/or flags and pulses done. A new instruction can be
// accepted every 4 cycles.
//
// Ports:
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : alu_exec_ctrl_if.slave carrying the decoder handshake, the ALU
//           operands/result/flags, the psr/done status and the debug read
module alu_exec_ctrl
  import alu_exec_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  alu_exec_ctrl_if.slave  bus
);

  state_t            r_state;
  state_t            w_nextState;

  logic [OP_W-1:0]   r_holdOp;
  logic [REG_AW-1:0] r_holdRdest;
  logic [REG_AW-1:0] r_holdRsrc;
  logic              r_holdWb;
  logic              r_holdFwe;
  logic [OP_W-1:0]   r_aluOp;
  logic [DATA_W-1:0] r_resC;
  logic [FLAG_W-1:0] r_resFlags;
  logic [FLAG_W-1:0] r_psr;

  logic              w_handshake;
  logic              w_rdEn;
  logic              w_we;
  logic [DATA_W-1:0] w_opA;
  logic [DATA_W-1:0] w_opB;

  // State register. Reset returns to IDLE, and this takes priority over any
  // handshake presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and strobe decode. in_ready is exactly "in IDLE". A valid
  // instruction seen in IDLE is therefore a handshake. in_valid in any
  // other state is ignored.
  always_comb begin
    w_nextState = r_state;
    w_handshake = 1'b0;
    w_rdEn      = 1'b0;
    w_we        = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_handshake = 1'b1;
          w_nextState = READ;
        end
      end
      READ: begin
        w_rdEn      = 1'b1;
        w_nextState = EXEC;
      end
      EXEC: begin
        w_nextState = WB;
      end
      WB: begin
        w_we        = r_holdWb;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Holding registers. These keep a copy of the decoded instruction so the
  // decoder is free to move on once it has been accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_holdOp    <= '0;
      r_holdRdest <= '0;
      r_holdRsrc  <= '0;
      r_holdWb    <= 1'b0;
      r_holdFwe   <= 1'b0;
    end else if (w_handshake) begin
      r_holdOp    <= bus.in_op;
      r_holdRdest <= bus.in_rdest;
      r_holdRsrc  <= bus.in_rsrc;
      r_holdWb    <= bus.in_wb;
      r_holdFwe   <= bus.in_fwe;
    end
  end

  // The opcode seen by the ALU is updated on the same edge as the operand
  // capture. This means op, a and b all switch together when EXEC starts
  // and otherwise hold their last values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_aluOp <= '0;
    end else if (r_state == READ) begin
      r_aluOp <= r_holdOp;
    end
  end

  // Capture the ALU result and flags at the end of EXEC. This way WB works
  // from stable copies rather than from the live ALU outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_resC     <= '0;
      r_resFlags <= '0;
    end else if (r_state == EXEC) begin
      r_resC     <= bus.alu_c;
      r_resFlags <= bus.alu_flags;
    end
  end

  // PSR update in WB, only for instructions that ask for it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_psr <= '0;
    end else if ((r_state == WB) && r_holdFwe) begin
      r_psr <= r_resFlags;
    end
  end

  alu_exec_ctrl_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .i_rdEn    (w_rdEn),
    .i_raddrA  (r_holdRdest),
    .i_raddrB  (r_holdRsrc),
    .o_rdataA  (w_opA),
    .o_rdataB  (w_opB),
    .i_we      (w_we),
    .i_waddr   (r_holdRdest),
    .i_wdata   (r_resC),
    .i_dbgAddr (bus.dbg_addr),
    .o_dbgData (bus.dbg_data)
  );

  // done is masked by reset. An instruction aborted during its WB cycle
  // therefore never reports retirement.
  assign bus.in_ready = (r_state == IDLE);
  assign bus.done     = (r_state == WB) && !reset;
  assign bus.alu_a    = w_opA;
  assign bus.alu_b    = w_opB;
  assign bus.alu_op   = r_aluOp;
  assign bus.alu_cin  = r_psr[PSR_C];
  assign bus.psr      = r_psr;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl
// Self-checking bench for alu_exec_ctrl. It contains a small behavioural
// ALU and drives instructions through the decoder handshake. Expected
// results go into a scoreboard queue at acceptance time. They are popped
// and compared when done is observed.
module tb_alu_exec_ctrl;
  import alu_exec_ctrl_pkg::*;

  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_MOVI = 8'h13;

  typedef struct {
    logic [3:0]  rd;
    logic [15:0] val;
    logic [4:0]  psr;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  op;
    logic        cin;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t sb[$];
  logic [4:0]  curPsr;
  logic [15:0] immVal;
  logic [15:0] aluC;
  logic [4:0]  aluFlags;
  logic [16:0] sum;

  alu_exec_ctrl_if bus ();

  alu_exec_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU. MOVI stands in for the decoder's immediate path. It
  // returns the bench-supplied immediate so registers can be preloaded.
  always_comb begin
    sum      = '0;
    aluC     = '0;
    aluFlags = '0;
    case (bus.alu_op)
      OP_ADD, OP_ADDU, OP_ADDC: begin
        sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} +
              ((bus.alu_op == OP_ADDC) ? {16'd0, bus.alu_cin} : 17'd0);
        aluC = sum[15:0];
        aluFlags[PSR_Z] = (sum[15:0] == 16'd0);
        aluFlags[PSR_C] = sum[16];
        aluFlags[PSR_O] = (bus.alu_op == OP_ADDU) ? sum[16] :
                          ((bus.alu_a[15] == bus.alu_b[15]) && (sum[15] != bus.alu_a[15]));
      end
      OP_CMP: begin
        aluC = bus.alu_a;
        aluFlags[PSR_Z] = (bus.alu_a == bus.alu_b);
        aluFlags[PSR_N] = ($signed(bus.alu_a) < $signed(bus.alu_b));
        aluFlags[PSR_L] = (bus.alu_a > bus.alu_b);
      end
      OP_XOR: begin
        aluC = bus.alu_a ^ bus.alu_b;
        aluFlags[PSR_Z] = ((bus.alu_a ^ bus.alu_b) == 16'd0);
      end
      OP_MOVI: begin
        aluC = immVal;
      end
      default: begin
        aluC = '0;
      end
    endcase
  end

  assign bus.alu_c     = aluC;
  assign bus.alu_flags = aluFlags;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic readReg(input logic [3:0] idx, input logic [15:0] exp, input string tag);
    bus.dbg_addr = idx;
    #1;
    checkOutput(tag, 32'(bus.dbg_data), 32'(exp));
  endtask

  // Drive one instruction, hold in_valid while busy, and then check
  // latency, the ALU-side values and the architectural result.
  task automatic applyStimulus(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                               input logic wb, input logic fwe, input logic [15:0] imm,
                               input logic [15:0] expA, input logic [15:0] expB,
                               input logic [15:0] expVal, input logic [4:0] expPsr);
    exp_t it;
    int waited;
    int lat;
    int busyReady;
    @(negedge clk);
    bus.in_op    = op;
    bus.in_rdest = rd;
    bus.in_rsrc  = rs;
    bus.in_wb    = wb;
    bus.in_fwe   = fwe;
    immVal       = imm;
    bus.in_valid = 1'b1;
    waited = 0;
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("accept", 32'(bus.in_ready), 32'd1);
    it.rd  = rd;
    it.val = expVal;
    it.psr = expPsr;
    it.a   = expA;
    it.b   = expB;
    it.op  = op;
    it.cin = curPsr[PSR_C];
    sb.push_back(it);
    curPsr = expPsr;
    lat = 0;
    busyReady = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.in_ready) busyReady++;
    end while (!bus.done && lat < 8);
    bus.in_valid = 1'b0;
    checkOutput("latency", 32'(lat), 32'd3);
    checkOutput("busyReady", 32'(busyReady), 32'd0);
    if (sb.size() > 0) begin
      it = sb.pop_front();
      checkOutput("alu_a", 32'(bus.alu_a), 32'(it.a));
      checkOutput("alu_b", 32'(bus.alu_b), 32'(it.b));
      checkOutput("alu_op", 32'(bus.alu_op), 32'(it.op));
      checkOutput("alu_cin", 32'(bus.alu_cin), 32'(it.cin));
      @(negedge clk);
      checkOutput("doneLow", 32'(bus.done), 32'd0);
      checkOutput("readyBack", 32'(bus.in_ready), 32'd1);
      readReg(it.rd, it.val, "regResult");
      checkOutput("psr", 32'(bus.psr), 32'(it.psr));
    end
  endtask

  // Watchdog so a stuck design still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int doneSeen;
    total        = 0;
    bad          = 0;
    curPsr       = '0;
    immVal       = '0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.in_rdest = '0;
    bus.in_rsrc  = '0;
    bus.in_wb    = 1'b0;
    bus.in_fwe   = 1'b0;
    bus.dbg_addr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rstReady", 32'(bus.in_ready), 32'd1);
    checkOutput("rstDone", 32'(bus.done), 32'd0);
    checkOutput("rstPsr", 32'(bus.psr), 32'd0);
    checkOutput("rstAluA", 32'(bus.alu_a), 32'd0);
    checkOutput("rstAluOp", 32'(bus.alu_op), 32'd0);
    readReg(4'd0, 16'h0000, "rstR0");
    readReg(4'd15, 16'h0000, "rstR15");

    // Reset and a handshake in the same cycle: the reset must win.
    bus.in_op    = OP_MOVI;
    bus.in_rdest = 4'd3;
    bus.in_rsrc  = 4'd3;
    bus.in_wb    = 1'b1;
    bus.in_fwe   = 1'b0;
    immVal       = 16'h0055;
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("rstPrioReady", 32'(bus.in_ready), 32'd1);

    $display("[TB] basic add");
    applyStimulus(OP_MOVI, 4'd1, 4'd1, 1'b1, 1'b0, 16'd3, 16'h0000, 16'h0000, 16'h0003, 5'b00000);
    applyStimulus(OP_MOVI, 4'd2, 4'd2, 1'b1, 1'b0, 16'd4, 16'h0000, 16'h0000, 16'h0004, 5'b00000);
    applyStimulus(OP_ADD,  4'd1, 4'd2, 1'b1, 1'b1, 16'd0, 16'h0003, 16'h0004, 16'h0007, 5'b00000);

    $display("[TB] unsigned add and carry-in");
    applyStimulus(OP_MOVI, 4'd1, 4'd1, 1'b1, 1'b0, 16'hFFFF, 16'h0007, 16'h0007, 16'hFFFF, 5'b00000);
    applyStimulus(OP_MOVI, 4'd2, 4'd2, 1'b1, 1'b0, 16'h0001, 16'h0004, 16'h0004, 16'h0001, 5'b00000);
    applyStimulus(OP_ADDU, 4'd1, 4'd2, 1'b1, 1'b1, 16'd0, 16'hFFFF, 16'h0001, 16'h0000, 5'b11100);
    applyStimulus(OP_ADDC, 4'd3, 4'd4, 1'b1, 1'b1, 16'd0, 16'h0000, 16'h0000, 16'h0001, 5'b00000);

    $display("[TB] compare without write-back");
    applyStimulus(OP_MOVI, 4'd5, 4'd5, 1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'h0000, 16'hFFFE, 5'b00000);
    applyStimulus(OP_MOVI, 4'd6, 4'd6, 1'b1, 1'b0, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 5'b00000);
    applyStimulus(OP_CMP,  4'd5, 4'd6, 1'b0, 1'b1, 16'd0, 16'hFFFE, 16'h0001, 16'hFFFE, 5'b00011);

    $display("[TB] xor without flag update");
    applyStimulus(OP_MOVI, 4'd7, 4'd7, 1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h0000, 16'h00FF, 5'b00011);
    applyStimulus(OP_XOR,  4'd7, 4'd7, 1'b1, 1'b0, 16'd0, 16'h00FF, 16'h00FF, 16'h0000, 5'b00011);

    $display("[TB] dependent chain");
    applyStimulus(OP_MOVI, 4'd1, 4'd1, 1'b1, 1'b0, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 5'b00011);
    applyStimulus(OP_MOVI, 4'd2, 4'd2, 1'b1, 1'b0, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 5'b00011);
    applyStimulus(OP_ADD,  4'd1, 4'd2, 1'b1, 1'b1, 16'd0, 16'h0001, 16'h0001, 16'h0002, 5'b00000);
    applyStimulus(OP_ADD,  4'd1, 4'd1, 1'b1, 1'b1, 16'd0, 16'h0002, 16'h0002, 16'h0004, 5'b00000);

    $display("[TB] edge registers writable");
    applyStimulus(OP_MOVI, 4'd15, 4'd15, 1'b1, 1'b0, 16'hABCD, 16'h0000, 16'h0000, 16'hABCD, 5'b00000);
    applyStimulus(OP_MOVI, 4'd0,  4'd0,  1'b1, 1'b0, 16'h1234, 16'h0000, 16'h0000, 16'h1234, 5'b00000);

    $display("[TB] reset during EXEC");
    applyStimulus(OP_MOVI, 4'd1, 4'd1, 1'b1, 1'b0, 16'h0009, 16'h0004, 16'h0004, 16'h0009, 5'b00000);
    applyStimulus(OP_MOVI, 4'd2, 4'd2, 1'b1, 1'b0, 16'h0009, 16'h0001, 16'h0001, 16'h0009, 5'b00000);
    @(negedge clk);
    bus.in_op    = OP_ADD;
    bus.in_rdest = 4'd1;
    bus.in_rsrc  = 4'd2;
    bus.in_wb    = 1'b1;
    bus.in_fwe   = 1'b1;
    bus.in_valid = 1'b1;
    checkOutput("abortAccept", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    doneSeen = 0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abortReady", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (bus.done) doneSeen++;
      @(negedge clk);
    end
    checkOutput("abortDone", 32'(doneSeen), 32'd0);
    checkOutput("abortPsr", 32'(bus.psr), 32'd0);
    checkOutput("abortAluA", 32'(bus.alu_a), 32'd0);
    readReg(4'd1, 16'h0000, "abortR1");
    readReg(4'd2, 16'h0000, "abortR2");
    readReg(4'd15, 16'h0000, "abortR15");
    checkOutput("sbEmpty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
